// File: rtl/seven_seg_driver_if.sv
// CPU-side register port of seven_seg_driver: write strobe, write data and read-back.
interface seven_seg_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    we_i;
  logic [4*NUM_DIGITS-1:0] data_i;
  logic [4*NUM_DIGITS-1:0] data_o;

  modport master (output we_i, output data_i, input  data_o);
  modport slave  (input  we_i, input  data_i, output data_o);
endinterface

// File: rtl/seven_seg_driver.sv
// Time-multiplexed common-anode hex display; outputs registered one cycle behind scan state, never stalls.
// SEVEN_SEG_LZ_BLANK_EN: when defined, leading-zero digits (except digit 0) show all segments off.
module seven_seg_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 10000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seven_seg_driver_if.slave     bus,
  input  logic                  en_i,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [6:0]            seg_o
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  localparam state_t ST_RST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  state_t                  r_state, w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_an, w_an_nxt;
  logic [6:0]              r_seg, w_seg_nxt;
  logic [3:0]              w_nib;
  logic                    w_lz;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic                    w_zero;
`endif

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'h40;
      4'h1:    f_decode = 7'h79;
      4'h2:    f_decode = 7'h24;
      4'h3:    f_decode = 7'h30;
      4'h4:    f_decode = 7'h19;
      4'h5:    f_decode = 7'h12;
      4'h6:    f_decode = 7'h02;
      4'h7:    f_decode = 7'h78;
      4'h8:    f_decode = 7'h00;
      4'h9:    f_decode = 7'h10;
      4'hA:    f_decode = 7'h08;
      4'hB:    f_decode = 7'h03;
      4'hC:    f_decode = 7'h46;
      4'hD:    f_decode = 7'h21;
      4'hE:    f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_RST;
      r_data  <= '0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      if (bus.we_i) r_data <= bus.data_i;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt + CW'(1);
    w_idx_nxt = r_idx;
    if (r_cnt == CNT_LAST) begin
      w_cnt_nxt = '0;
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end
    w_state_nxt = (w_cnt_nxt < CNT_SHOW) ? ST_BLANK : ST_SHOW;

    w_nib = r_data[3:0];
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_idx == IW'(k)) w_nib = r_data[4*k +: 4];

    w_lz = 1'b0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Walk down from the top nibble; digit 0 is excluded so zero still reads "0".
    w_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_zero = w_zero & (r_data[4*k +: 4] == 4'h0);
      if (r_idx == IW'(k)) w_lz = w_zero;
    end
`endif

    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    if (en_i && r_state == ST_SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++)
        if (r_idx == IW'(k)) w_an_nxt[k] = 1'b0;
      if (!w_lz) w_seg_nxt = f_decode(w_nib);
    end
  end

  assign an_o        = r_an;
  assign seg_o       = r_seg;
  assign bus.data_o  = r_data;

endmodule

// File: tb/tb_seven_seg_driver.sv
// Randomized self-checking bench for seven_seg_driver against a slot-level reference model.
module tb_seven_seg_driver;
  localparam int ND   = 4;
  localparam int RDIV = 8;
  localparam int BLK  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          en_i  = 1'b1;
  logic [ND-1:0] an_o;
  logic [6:0]    seg_o;

  seven_seg_driver_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_driver #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .en_i  (en_i),
    .an_o  (an_o),
    .seg_o (seg_o)
  );

  always #5 clk_i = ~clk_i;

  logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int            n_cmp = 0;
  int            n_err = 0;
  int            m_cnt, m_idx;
  logic [15:0]   m_data;
  logic [ND-1:0] m_an;
  logic [6:0]    m_seg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_idx  = 0;
    m_data = '0;
    m_an   = '1;
    m_seg  = 7'h7F;
  endtask

  // One clock edge of the display as seen from outside: outputs reflect the pre-edge slot.
  task automatic model_edge();
    logic [15:0] upper;
    if (!rst_i) begin
      model_reset();
      return;
    end
    m_an  = '1;
    m_seg = 7'h7F;
    if (en_i && m_cnt >= BLK) begin
      upper        = m_data >> (4 * m_idx);
      m_an[m_idx]  = 1'b0;
      m_seg        = DEC[upper[3:0]];
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (m_idx != 0 && upper == 16'h0) m_seg = 7'h7F;
`endif
    end
    if (bus.we_i) m_data = bus.data_i;
    if (m_cnt == RDIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % ND;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_all();
    check_eq("an", 32'(an_o), 32'(m_an));
    check_eq("seg", 32'(seg_o), 32'(m_seg));
    check_eq("data_o", 32'(bus.data_o), 32'(m_data));
    check_eq("an_onehot", 32'($countones(~an_o) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1 check_all();
  endtask

  task automatic write(input logic [15:0] v);
    bus.we_i   = 1'b1;
    bus.data_i = v;
    tick();
    bus.we_i   = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Assert reset between edges, check the off state before any clock edge, then release.
  task automatic async_reset_pulse(input int hold);
    #2 rst_i = 1'b0;
    model_reset();
    #1 check_all();
    check_eq("rst_async_an", 32'(an_o), 32'hF);
    run(hold);
    #2 rst_i = 1'b1;
  endtask

  initial begin
    bit found;
    bus.we_i   = 1'b0;
    bus.data_i = '0;
    model_reset();

    // Reset held, then release and watch first digit-0 SHOW after BLANK.
    run(3);
    check_eq("rst_seg", 32'(seg_o), 32'h7F);
    #3 rst_i = 1'b1;
    run(2);
    check_eq("post_rst_blank_an", 32'(an_o), 32'hF);
    tick();
    check_eq("first_show_an", 32'(an_o), 32'he);
    check_eq("first_show_seg", 32'(seg_o), 32'h40);

    // Basic scan of a mixed value.
    write(16'h12AF);
    check_eq("wr_data_o", 32'(bus.data_o), 32'h12AF);
    run(32);

    // Enable off mid-scan, then back on.
    en_i = 1'b0;
    run(11);
    en_i = 1'b1;
    run(20);

    // Write landing on the digit-0 -> digit-1 slot change.
    write(16'h0000);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_cnt == RDIV - 1 && m_idx == 0) found = 1'b1;
      else tick();
    end
    if (!found) check_eq("wrap_wait", 32'd0, 32'd1);
    write(16'h8888);
    run(16);

    // Async reset while a digit is showing.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an_o != 4'hF) found = 1'b1;
      else tick();
    end
    if (!found) check_eq("show_wait", 32'd0, 32'd1);
    async_reset_pulse(2);
    run(12);

    // Leading-zero patterns (blanked only in the macro build; model follows the build).
    write(16'h0050);
    run(32);
    write(16'h0000);
    run(32);

    // Random writes, enable toggles and occasional async resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.we_i   = 1'b1;
        bus.data_i = 16'($urandom);
        if ($urandom_range(0, 1) == 0) bus.data_i = bus.data_i >> (4 * $urandom_range(1, 3));
      end else begin
        bus.we_i = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) en_i = ~en_i;
      tick();
      if ($urandom_range(0, 149) == 0) begin
        bus.we_i = 1'b0;
        async_reset_pulse($urandom_range(0, 2));
      end
    end
    bus.we_i = 1'b0;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
